// File: rtl/vend_key_ctrl_if.sv
// vend_key_ctrl_if: scanner input, change handshake and status bundle.
// slave = controller side, master = scanner/actuator side.
interface vend_key_ctrl_if;
  logic       key_valid;
  logic [3:0] key_value;
  logic       change_ack;
  logic       key_evt;
  logic [3:0] key_code;
  logic [7:0] credit;
  logic [3:0] sel_code;
  logic       sel_valid;
  logic       vend_pulse;
  logic [3:0] vend_code;
  logic       change_valid;
  logic [7:0] change;
  logic       err;
  logic       busy;
`ifdef VEND_TIMEOUT_EN
  logic       timeout_pulse;

  modport slave (
    input  key_valid, key_value, change_ack,
    output key_evt, key_code, credit,
    output sel_code, sel_valid,
    output vend_pulse, vend_code,
    output change_valid, change,
    output err, busy, timeout_pulse
  );

  modport master (
    output key_valid, key_value, change_ack,
    input  key_evt, key_code, credit,
    input  sel_code, sel_valid,
    input  vend_pulse, vend_code,
    input  change_valid, change,
    input  err, busy, timeout_pulse
  );
`else
  modport slave (
    input  key_valid, key_value, change_ack,
    output key_evt, key_code, credit,
    output sel_code, sel_valid,
    output vend_pulse, vend_code,
    output change_valid, change,
    output err, busy
  );

  modport master (
    output key_valid, key_value, change_ack,
    input  key_evt, key_code, credit,
    input  sel_code, sel_valid,
    input  vend_pulse, vend_code,
    input  change_valid, change,
    input  err, busy
  );
`endif
endinterface

// File: rtl/vend_key_ctrl.sv
// vend_key_ctrl: keypad debounce + vending transaction FSM.
// Ports: clk, reset (async, active-low), bus (vend_key_ctrl_if.slave):
//   in  key_valid/key_value (scanner), change_ack (dispenser)
//   out key_evt/key_code, credit, sel_code/sel_valid,
//       vend_pulse/vend_code, change_valid/change, err, busy
// Option macro VEND_TIMEOUT_EN: adds TIMEOUT_CYCLES and timeout_pulse.
module vend_key_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COIN_VALUE      = 5,
  parameter int PRICE_BASE      = 10,
  parameter int PRICE_STEP      = 5,
  parameter int MAX_CREDIT      = 95
`ifdef VEND_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES  = 1000
`endif
) (
  input logic            clk,
  input logic            reset,
  vend_key_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    CREDIT,
    VEND,
    CHANGE
  } state_t;

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES);

  // ---------------- debounce ----------------
  logic [3:0]    prev_q;
  logic          prev_vld_q;
  logic [DW-1:0] hold_q, hold_d;
  logic [DW-1:0] rel_q, rel_d;
  logic          latch_q;
  logic          evt_q;
  logic [3:0]    code_q;
  logic          same;

  always_comb begin
    same   = bus.key_valid && prev_vld_q &&
             (bus.key_value == prev_q);
    hold_d = '0;
    rel_d  = '0;
    if (same)
      hold_d = (hold_q == DB_MAX) ? hold_q : hold_q + 1'b1;
    else if (bus.key_valid)
      hold_d = DW'(1);
    if (!bus.key_valid)
      rel_d = (rel_q == DB_MAX) ? rel_q : rel_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      hold_q     <= '0;
      rel_q      <= '0;
      latch_q    <= 1'b0;
      evt_q      <= 1'b0;
      code_q     <= '0;
    end else begin
      prev_q     <= bus.key_value;
      prev_vld_q <= bus.key_valid;
      hold_q     <= hold_d;
      rel_q      <= rel_d;
      evt_q      <= 1'b0;
      if (hold_d == DB_MAX && !latch_q) begin
        latch_q <= 1'b1;
        code_q  <= bus.key_value;
        evt_q   <= 1'b1;
      end else if (rel_d == DB_MAX) begin
        latch_q <= 1'b0;
      end
    end
  end

  // ---------------- transaction FSM ----------------
  state_t     state_q, state_d;
  logic [7:0] credit_q, credit_d;
  logic [7:0] change_q, change_d;
  logic [3:0] sel_q, sel_d;
  logic [3:0] vcode_q, vcode_d;
  logic       sel_v_q, sel_v_d;
  logic       vend_q, vend_d;
  logic       chg_v_q, chg_v_d;
  logic       err_q, err_d;
  logic [7:0] price;
  logic [8:0] coin_sum;
  logic [7:0] remain;
  logic       is_digit, is_coin;
  logic       is_cancel, is_conf;

  assign price    = 8'(PRICE_BASE) + 8'(sel_q) * 8'(PRICE_STEP);
  assign coin_sum = {1'b0, credit_q} + 9'(COIN_VALUE);
  assign remain   = credit_q - price;

  assign is_digit  = code_q <= 4'd9;
  assign is_coin   = code_q == 4'hA;
  assign is_cancel = code_q == 4'hB;
  assign is_conf   = code_q == 4'hC;

`ifdef VEND_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
  logic          tmo_hit;
  logic          tmo_p_q, tmo_p_d;

  // Counter restarts on any key event and only runs in CREDIT.
  assign tmo_hit = (state_q == CREDIT) && !evt_q &&
                   (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q   <= '0;
      tmo_p_q <= 1'b0;
    end else begin
      tmo_p_q <= tmo_p_d;
      if (evt_q || state_q != CREDIT)
        tmo_q <= '0;
      else
        tmo_q <= tmo_q + 1'b1;
    end
  end

  assign bus.timeout_pulse = tmo_p_q;
`endif

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    change_d = change_q;
    sel_d    = sel_q;
    vcode_d  = vcode_q;
    sel_v_d  = sel_v_q;
    vend_d   = 1'b0;
    chg_v_d  = chg_v_q;
    err_d    = 1'b0;
`ifdef VEND_TIMEOUT_EN
    tmo_p_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE, CREDIT: begin
        if (evt_q) begin
          unique case (1'b1)
            is_digit: begin
              sel_d   = code_q;
              sel_v_d = 1'b1;
            end
            is_coin: begin
              if (coin_sum > 9'(MAX_CREDIT)) begin
                err_d = 1'b1;
              end else begin
                credit_d = coin_sum[7:0];
                state_d  = CREDIT;
              end
            end
            is_conf: begin
              if (sel_v_q && credit_q >= price) begin
                state_d = VEND;
                vend_d  = 1'b1;
                vcode_d = sel_q;
              end else begin
                err_d = 1'b1;
              end
            end
            is_cancel: begin
              if (credit_q != 8'd0) begin
                change_d = credit_q;
                chg_v_d  = 1'b1;
                state_d  = CHANGE;
              end else begin
                sel_v_d = 1'b0;
              end
            end
            default: ;
          endcase
        end
`ifdef VEND_TIMEOUT_EN
        else if (tmo_hit) begin
          change_d = credit_q;
          chg_v_d  = 1'b1;
          state_d  = CHANGE;
          tmo_p_d  = 1'b1;
        end
`endif
      end
      VEND: begin
        credit_d = remain;
        sel_v_d  = 1'b0;
        if (remain != 8'd0) begin
          change_d = remain;
          chg_v_d  = 1'b1;
          state_d  = CHANGE;
        end else begin
          state_d = IDLE;
        end
      end
      CHANGE: begin
        if (bus.change_ack) begin
          chg_v_d  = 1'b0;
          change_d = '0;
          credit_d = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      credit_q <= '0;
      change_q <= '0;
      sel_q    <= '0;
      vcode_q  <= '0;
      sel_v_q  <= 1'b0;
      vend_q   <= 1'b0;
      chg_v_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      change_q <= change_d;
      sel_q    <= sel_d;
      vcode_q  <= vcode_d;
      sel_v_q  <= sel_v_d;
      vend_q   <= vend_d;
      chg_v_q  <= chg_v_d;
      err_q    <= err_d;
    end
  end

  assign bus.key_evt      = evt_q;
  assign bus.key_code     = code_q;
  assign bus.credit       = credit_q;
  assign bus.sel_code     = sel_q;
  assign bus.sel_valid    = sel_v_q;
  assign bus.vend_pulse   = vend_q;
  assign bus.vend_code    = vcode_q;
  assign bus.change_valid = chg_v_q;
  assign bus.change       = change_q;
  assign bus.err          = err_q;
  assign bus.busy         = (state_q == VEND) ||
                            (state_q == CHANGE);

endmodule

// File: tb/tb_vend_key_ctrl.sv
// tb_vend_key_ctrl: scoreboard bench for vend_key_ctrl.
// Key/vend codes queued at stimulus, popped by an output monitor.
module tb_vend_key_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vend_key_ctrl_if vif ();

`ifdef VEND_TIMEOUT_EN
  vend_key_ctrl #(.TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .reset(reset), .bus(vif)
  );
`else
  vend_key_ctrl dut (
    .clk(clk), .reset(reset), .bus(vif)
  );
`endif

  int vectors = 0;
  int miscompares = 0;
  int n_evt = 0;
  int n_vend = 0;
  int n_err = 0;
  logic [3:0] exp_key[$];
  logic [3:0] exp_vend[$];
  logic [3:0] mon_e;

  // Output monitor: compares every key_evt / vend_pulse with the queues.
  always @(negedge clk) begin
    if (reset) begin
      if (vif.key_evt) begin
        n_evt++;
        vectors++;
        if (exp_key.size() == 0) begin
          miscompares++;
          $display("FAIL key_evt_unexpected got=%0h", vif.key_code);
        end else begin
          mon_e = exp_key.pop_front();
          if (vif.key_code !== mon_e) begin
            miscompares++;
            $display("FAIL key_code got=%0h exp=%0h", vif.key_code, mon_e);
          end
        end
      end
      if (vif.vend_pulse) begin
        n_vend++;
        vectors++;
        if (exp_vend.size() == 0) begin
          miscompares++;
          $display("FAIL vend_unexpected got=%0h", vif.vend_code);
        end else begin
          mon_e = exp_vend.pop_front();
          if (vif.vend_code !== mon_e) begin
            miscompares++;
            $display("FAIL vend_code got=%0h exp=%0h", vif.vend_code, mon_e);
          end
        end
      end
      if (vif.err) n_err++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] code);
    exp_key.push_back(code);
    vif.key_valid = 1'b1;
    vif.key_value = code;
    repeat (6) tick();
    vif.key_valid = 1'b0;
    vif.key_value = 4'h0;
    repeat (6) tick();
  endtask

  task automatic coins(input int n);
    for (int i = 0; i < n; i++) press(4'hA);
  endtask

  task automatic ack();
    vif.change_ack = 1'b1;
    tick();
    vif.change_ack = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    vif.key_valid  = 1'b0;
    vif.key_value  = 4'h0;
    vif.change_ack = 1'b0;
    reset = 1'b0;
    #12;
    vectors++;
    if ({vif.key_evt, vif.credit, vif.sel_valid, vif.vend_pulse,
         vif.change_valid, vif.change, vif.err, vif.busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_outs credit=%0d busy=%0b chg_v=%0b exp=0",
               vif.credit, vif.busy, vif.change_valid);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    vectors++;
    if (vif.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy got=%0b exp=0", vif.busy);
    end
  endtask

  task automatic test_bounce();
    logic pat [10] = '{1, 1, 0, 0, 1, 1, 0, 0, 0, 0};
    int k0;
    k0 = n_evt;
    for (int i = 0; i < 10; i++) begin
      vif.key_valid = pat[i];
      vif.key_value = 4'h3;
      tick();
    end
    exp_key.push_back(4'h3);
    vif.key_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (vif.key_evt !== (i == 3)) begin
        miscompares++;
        $display("FAIL bounce_evt_timing s=%0d got=%0b exp=%0b",
                 i + 1, vif.key_evt, i == 3);
      end
    end
    repeat (2) tick();
    vif.key_valid = 1'b0;
    repeat (2) tick();
    vif.key_valid = 1'b1;
    repeat (6) tick();
    vif.key_valid = 1'b0;
    repeat (6) tick();
    vectors++;
    if (n_evt - k0 !== 1) begin
      miscompares++;
      $display("FAIL bounce_evt_count got=%0d exp=1", n_evt - k0);
    end
    vectors++;
    if (vif.sel_code !== 4'h3 || vif.sel_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bounce_sel got=%0h/%0b exp=3/1",
               vif.sel_code, vif.sel_valid);
    end
  endtask

  task automatic test_happy_vend();
    int v0;
    coins(5);
    vectors++;
    if (vif.credit !== 8'd25) begin
      miscompares++;
      $display("FAIL happy_credit got=%0d exp=25", vif.credit);
    end
    press(4'h2);
    v0 = n_vend;
    exp_vend.push_back(4'h2);
    press(4'hC);
    vectors++;
    if (n_vend - v0 !== 1) begin
      miscompares++;
      $display("FAIL happy_vend_count got=%0d exp=1", n_vend - v0);
    end
    repeat (3) tick();
    vectors++;
    if (vif.change_valid !== 1'b1 || vif.change !== 8'd5 ||
        vif.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL happy_change got=%0b/%0d/%0b exp=1/5/1",
               vif.change_valid, vif.change, vif.busy);
    end
    ack();
    vectors++;
    if (vif.change_valid !== 1'b0 || vif.credit !== 8'd0 ||
        vif.busy !== 1'b0 || vif.sel_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL happy_done got=%0b/%0d/%0b/%0b exp=0/0/0/0",
               vif.change_valid, vif.credit, vif.busy, vif.sel_valid);
    end
  endtask

  task automatic test_insufficient();
    int e0, v0;
    coins(2);
    press(4'h9);
    e0 = n_err;
    v0 = n_vend;
    press(4'hC);
    vectors++;
    if (n_err - e0 !== 1) begin
      miscompares++;
      $display("FAIL insuf_err got=%0d exp=1", n_err - e0);
    end
    vectors++;
    if (vif.credit !== 8'd10 || vif.sel_valid !== 1'b1 ||
        n_vend != v0 || vif.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL insuf_state got=%0d/%0b/%0d exp=10/1/0",
               vif.credit, vif.sel_valid, n_vend - v0);
    end
    press(4'hB);
    ack();
  endtask

  task automatic test_saturation();
    int e0;
    coins(19);
    vectors++;
    if (vif.credit !== 8'd95) begin
      miscompares++;
      $display("FAIL sat_credit got=%0d exp=95", vif.credit);
    end
    e0 = n_err;
    press(4'hA);
    vectors++;
    if (n_err - e0 !== 1 || vif.credit !== 8'd95) begin
      miscompares++;
      $display("FAIL sat_limit err=%0d credit=%0d exp=1/95",
               n_err - e0, vif.credit);
    end
    press(4'hB);
    vectors++;
    if (vif.change_valid !== 1'b1 || vif.change !== 8'd95) begin
      miscompares++;
      $display("FAIL sat_change got=%0b/%0d exp=1/95",
               vif.change_valid, vif.change);
    end
    ack();
  endtask

  task automatic test_dropped_keys();
    int v0, k0, e0;
    coins(3);
    v0 = n_vend;
    press(4'hB);
    vectors++;
    if (vif.change_valid !== 1'b1 || vif.change !== 8'd15 ||
        n_vend != v0) begin
      miscompares++;
      $display("FAIL cancel_change got=%0b/%0d exp=1/15",
               vif.change_valid, vif.change);
    end
    k0 = n_evt;
    e0 = n_err;
    press(4'h5);
    press(4'hA);
    press(4'hC);
    vectors++;
    if (n_evt - k0 !== 3 || n_err != e0) begin
      miscompares++;
      $display("FAIL drop_events evt=%0d err=%0d exp=3/0",
               n_evt - k0, n_err - e0);
    end
    vectors++;
    if (vif.credit !== 8'd15 || vif.change !== 8'd15 ||
        vif.busy !== 1'b1 || n_vend != v0) begin
      miscompares++;
      $display("FAIL drop_state got=%0d/%0d/%0b exp=15/15/1",
               vif.credit, vif.change, vif.busy);
    end
    ack();
    press(4'h4);
    vectors++;
    if (vif.sel_valid !== 1'b1 || vif.sel_code !== 4'h4) begin
      miscompares++;
      $display("FAIL sel4 got=%0b/%0h exp=1/4",
               vif.sel_valid, vif.sel_code);
    end
    e0 = n_err;
    press(4'hB);
    vectors++;
    if (n_err != e0 || vif.sel_valid !== 1'b0 ||
        vif.change_valid !== 1'b0 || vif.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL cancel_zero err=%0d sel_v=%0b exp=0/0",
               n_err - e0, vif.sel_valid);
    end
  endtask

  task automatic test_reset_mid_change();
    press(4'h7);
    coins(1);
    press(4'hB);
    vectors++;
    if (vif.change_valid !== 1'b1 || vif.change !== 8'd5) begin
      miscompares++;
      $display("FAIL pre_reset got=%0b/%0d exp=1/5",
               vif.change_valid, vif.change);
    end
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if ({vif.key_code, vif.credit, vif.sel_code, vif.sel_valid,
         vif.vend_code, vif.change_valid, vif.change,
         vif.busy} !== '0) begin
      miscompares++;
      $display("FAIL async_reset credit=%0d chg_v=%0b sel=%0h exp=0",
               vif.credit, vif.change_valid, vif.sel_code);
    end
    repeat (2) tick();
    @(negedge clk);
    reset = 1'b1;
    tick();
    coins(1);
    vectors++;
    if (vif.credit !== 8'd5 || vif.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset got=%0d/%0b exp=5/0",
               vif.credit, vif.busy);
    end
    press(4'hB);
    ack();
  endtask

`ifdef VEND_TIMEOUT_EN
  task automatic test_timeout();
    bit seen;
    seen = 1'b0;
    coins(1);
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (vif.timeout_pulse) begin
        seen = 1'b1;
        vectors++;
        if (vif.change_valid !== 1'b1 || vif.change !== 8'd5) begin
          miscompares++;
          $display("FAIL timeout_change got=%0b/%0d exp=1/5",
                   vif.change_valid, vif.change);
        end
      end
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL timeout_pulse got=0 exp=1");
    end
    ack();
  endtask
`endif

  initial begin
    test_reset();
    test_bounce();
    test_happy_vend();
    test_insufficient();
    test_saturation();
    test_dropped_keys();
    test_reset_mid_change();
`ifdef VEND_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) tick();
    vectors++;
    if (exp_key.size() != 0 || exp_vend.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_left key=%0d vend=%0d exp=0/0",
               exp_key.size(), exp_vend.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vend_key_ctrl.md
Name: vend_key_ctrl

Overview:
- Downstream consumer of the 4x4 keypad scanner; sits between the scanner and the vending actuator/coin-return logic.
- Debounces the scanner's raw key_value/key-present pair into one event per physical press.
- Interprets key events as coin, digit-select, confirm and cancel commands.
- Runs the vending transaction FSM: credit accumulation, price check, vend pulse, change handshake.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive identical samples needed to accept a press or a release (>=2)
COIN_VALUE, 5, credit added per coin key (A)
PRICE_BASE, 10, price of product 0
PRICE_STEP, 5, price increment per product index (price = PRICE_BASE + digit*PRICE_STEP, 8-bit, must be <=255 for digit 9)
MAX_CREDIT, 95, credit saturation limit (<=255)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
key_valid  input  1  scanner key-present level (high while any key is held)
key_value  input  4  scanner key code, 0x0-0xF
change_ack  input  1  change dispenser accepted change amount
key_evt  output  1  one-cycle pulse per debounced press
key_code  output  4  code of last debounced press
credit  output  8  current credit
sel_code  output  4  selected product digit
sel_valid  output  1  a product is selected
vend_pulse  output  1  one-cycle dispense strobe
vend_code  output  4  product dispensed, valid with vend_pulse
change_valid  output  1  change amount pending
change  output  8  change amount, stable while change_valid
err  output  1  one-cycle pulse on rejected command
busy  output  1  high in VEND or CHANGE

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, named reset. Asserting reset clears every output and internal register to 0 immediately, state to IDLE, in any state including mid-transaction; credit is lost.
- Debounce:
  - Counter increments while key_valid=1 and key_value equals the previous sample; it clears on any change or when key_valid=0.
  - On the DEBOUNCE_CYCLES-th consecutive stable sample, if not already latched: latch the press, set key_code, and pulse key_evt on the next cycle.
  - The latch clears only after key_valid=0 for DEBOUNCE_CYCLES consecutive cycles, so each press yields exactly one event.
  - A different key while latched produces no event.
- Key map: 0-9 digit; A coin; B cancel; C confirm; D/E/F ignored (key_evt still pulses).
- The FSM acts on key_evt in the same cycle; its outputs are registered, so the effect is visible the cycle after key_evt.
- States: IDLE, CREDIT, VEND, CHANGE.
- IDLE/CREDIT:
  - digit: sel_code=digit, sel_valid=1; a later digit overwrites.
  - A: credit+=COIN_VALUE and go to CREDIT. If the sum would exceed MAX_CREDIT, credit is unchanged and err pulses.
  - C: if sel_valid and credit>=price, go to VEND. Otherwise err pulses and nothing changes.
  - B: if credit>0, change=credit, change_valid=1, go to CHANGE. If credit==0, clear sel_valid only, with no err.
- VEND (1 cycle):
  - vend_pulse=1, vend_code=sel_code, credit-=price, sel_valid=0.
  - If the remainder is >0, load change, set change_valid and go to CHANGE. Otherwise go to IDLE.
- CHANGE:
  - Hold change_valid/change until change_ack=1.
  - On that cycle, change_valid drops next cycle, credit=0, and the state goes to IDLE.
  - change_ack outside CHANGE is ignored.
- Key events arriving in VEND/CHANGE are dropped: key_evt still pulses, but there is no FSM effect and no err.
- busy=1 exactly in VEND and CHANGE.
- All credit arithmetic is 8-bit unsigned; subtraction only occurs when credit>=price, so there is no underflow.

Optional Feature:
- Macro: VEND_TIMEOUT_EN.
- When defined:
  - Adds parameter TIMEOUT_CYCLES (default 1000) and a counter.
  - The counter clears on every key_evt and runs while in CREDIT.
  - On reaching TIMEOUT_CYCLES, the block behaves exactly as a cancel key: change=credit, go to CHANGE.
  - Adds output timeout_pulse, 1 cycle, coincident with the transition into CHANGE.
- When undefined: no counter, no port, and CREDIT holds indefinitely.

Test Plan:
- Bounce: key_valid/key_value=3 toggling every 2 cycles for 10 cycles, then stable for 4 cycles, then released -> exactly one key_evt, key_code=3, following the 4th stable sample. Re-press before 4 released cycles -> no second event.
- Happy vend: 5xA (credit 25), digit 2, C -> one vend_pulse with vend_code=2; change_valid=1 with change=5 held until change_ack; then credit=0, state IDLE, busy=0.
- Insufficient credit: 2xA (credit 10), digit 9 (price 55), C -> err pulse; credit stays 10; no vend_pulse; sel_valid=1.
- Saturation: 19xA -> credit 95; 20th A -> err pulse, credit 95. Then B -> change=95.
- Cancel/dropped keys: credit 15, B -> change=15, no vend_pulse. Keys pressed during CHANGE -> key_evt pulses, credit/state unchanged. B at credit 0 -> no err.
- Reset mid-CHANGE: assert reset with change_valid=1 -> all outputs 0 asynchronously, IDLE after release. With VEND_TIMEOUT_EN and TIMEOUT_CYCLES=20: 1xA then idle 20 cycles -> timeout_pulse, change=5.
